// File: rtl/fifo_top_if.sv
// Handshake bundle for the synchronous FIFO: write side, read side and status flags.
interface inFIFO #(
  parameter int DATA_WIDTH = 8
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;

  modport fifoIn (
    input  push,
    input  data_in,
    input  pop,
    output data_out,
    output full,
    output empty
  );
endinterface

// File: rtl/fifo_top.sv
// Single-clock FIFO of DEPTH x DATA_WIDTH words with a registered read port
// and flags derived from an occupancy count.
module fifo_top #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input logic   clk,
  input logic   rst,
  inFIFO.fifoIn bus
);
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign bus.full     = (count == FULL_CNT);
  assign bus.empty    = (count == '0);
  assign bus.data_out = data_out_q;

  // A pop on a full FIFO frees the slot the same edge, so the push may proceed.
  assign pop_ok  = bus.pop && !bus.empty;
  assign push_ok = bus.push && (!bus.full || bus.pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr     <= rd_ptr + AW'(1);
        data_out_q <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.data_in;
  end
endmodule

// File: tb/tb_fifo_top.sv
// Randomized and directed bench for fifo_top against a queue-based FIFO model.
module tb_fifo_top;
  localparam int DW = 8;
  localparam int DP = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inFIFO #(.DATA_WIDTH(DW)) bus_if ();

  fifo_top #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_do = '0;
  int n_checks = 0;
  int n_fail   = 0;

  // Drive one cycle's request, advance the model at the edge, settle 1 unit past it.
  task automatic cycle(input logic pu, input logic [DW-1:0] d, input logic po);
    bit push_acc, pop_acc;
    bus_if.push    = pu;
    bus_if.data_in = d;
    bus_if.pop     = po;
    @(posedge clk);
    if (rst) begin
      pop_acc  = po && (q.size() > 0);
      push_acc = pu && ((q.size() < DP) || po);
      if (pop_acc) exp_do = q.pop_front();
      if (push_acc) q.push_back(d);
    end
    #1;
    bus_if.push = 1'b0;
    bus_if.pop  = 1'b0;
  endtask

  task automatic do_reset();
    bus_if.push = 1'b0;
    bus_if.pop  = 1'b0;
    rst = 1'b0;
    q.delete();
    exp_do = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bus_if.push = 1'b0; bus_if.pop = 1'b0; bus_if.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle(1'b1, 8'h5A, 1'b0);  // ignored while held in reset
    n_checks++;
    if (bus_if.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", bus_if.empty); end
    n_checks++;
    if (bus_if.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", bus_if.full); end
    n_checks++;
    if (bus_if.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got %h want 00", bus_if.data_out); end
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus_if.empty !== 1'b1 || bus_if.data_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_push_ignored got empty=%b dout=%h want 1/00", bus_if.empty, bus_if.data_out);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DP; i++) begin
      cycle(1'b1, DW'(i + 1), 1'b0);
      n_checks++;
      if (bus_if.full !== (i == DP - 1) || bus_if.empty !== 1'b0) begin
        n_fail++; $display("FAIL fill_flags[%0d] got full=%b empty=%b want %b/0", i, bus_if.full, bus_if.empty, i == DP - 1);
      end
    end
    cycle(1'b1, 8'hFF, 1'b0);
    n_checks++;
    if (bus_if.full !== 1'b1) begin n_fail++; $display("FAIL overflow_full got %b want 1", bus_if.full); end
    for (int i = 0; i < DP; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus_if.data_out !== DW'(i + 1) || bus_if.data_out !== exp_do) begin
        n_fail++; $display("FAIL drain_data[%0d] got %h want %h", i, bus_if.data_out, DW'(i + 1));
      end
    end
    n_checks++;
    if (bus_if.empty !== 1'b1 || bus_if.full !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty got empty=%b full=%b want 1/0", bus_if.empty, bus_if.full);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus_if.data_out !== 8'h00 || bus_if.empty !== 1'b1) begin
        n_fail++; $display("FAIL underflow[%0d] got dout=%h empty=%b want 00/1", i, bus_if.data_out, bus_if.empty);
      end
    end
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus_if.data_out !== 8'hA5 || bus_if.empty !== 1'b1) begin
      n_fail++; $display("FAIL underflow_recover got dout=%h empty=%b want a5/1", bus_if.data_out, bus_if.empty);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) cycle(1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus_if.data_out !== exp_do) begin n_fail++; $display("FAIL wrap_pre[%0d] got %h want %h", i, bus_if.data_out, exp_do); end
    end
    for (int i = 0; i < DP; i++) cycle(1'b1, DW'(8'h20 + i), 1'b0);
    n_checks++;
    if (bus_if.full !== 1'b1) begin n_fail++; $display("FAIL wrap_full got %b want 1", bus_if.full); end
    for (int i = 0; i < DP; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus_if.data_out !== DW'(8'h20 + i)) begin
        n_fail++; $display("FAIL wrap_data[%0d] got %h want %h", i, bus_if.data_out, DW'(8'h20 + i));
      end
    end
    n_checks++;
    if (bus_if.empty !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b want 1", bus_if.empty); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h40 + i), 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, DW'(8'h50 + i), 1'b1);
      n_checks++;
      if (bus_if.data_out !== exp_do || q.size() != 5 || bus_if.full !== 1'b0 || bus_if.empty !== 1'b0) begin
        n_fail++; $display("FAIL simul[%0d] got dout=%h full=%b empty=%b want %h/0/0", i, bus_if.data_out, bus_if.full, bus_if.empty, exp_do);
      end
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus_if.data_out !== DW'(8'h53 + i)) begin
        n_fail++; $display("FAIL simul_rest[%0d] got %h want %h", i, bus_if.data_out, DW'(8'h53 + i));
      end
    end
    n_checks++;
    if (bus_if.empty !== 1'b1) begin n_fail++; $display("FAIL simul_count got empty=%b want 1", bus_if.empty); end
    cycle(1'b1, 8'h77, 1'b1);  // push+pop on empty: only the push lands
    n_checks++;
    if (bus_if.empty !== 1'b0 || bus_if.data_out !== exp_do) begin
      n_fail++; $display("FAIL simul_empty got empty=%b dout=%h want 0/%h", bus_if.empty, bus_if.data_out, exp_do);
    end
    for (int i = 1; i < DP; i++) cycle(1'b1, DW'(8'h80 + i), 1'b0);
    cycle(1'b1, 8'hC3, 1'b1);
    n_checks++;
    if (bus_if.full !== 1'b1 || bus_if.data_out !== 8'h77) begin
      n_fail++; $display("FAIL simul_full got full=%b dout=%h want 1/77", bus_if.full, bus_if.data_out);
    end
    for (int i = 0; i < DP; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      n_checks++;
      if (bus_if.data_out !== exp_do) begin n_fail++; $display("FAIL simul_drain[%0d] got %h want %h", i, bus_if.data_out, exp_do); end
    end
    n_checks++;
    if (exp_do !== 8'hC3 || bus_if.empty !== 1'b1) begin
      n_fail++; $display("FAIL simul_last got dout=%h empty=%b want c3/1", bus_if.data_out, bus_if.empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'h90 + i), 1'b0);
    #2;
    rst = 1'b0;
    q.delete();
    exp_do = '0;
    #1;
    n_checks++;
    if (bus_if.empty !== 1'b1 || bus_if.full !== 1'b0 || bus_if.data_out !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset got empty=%b full=%b dout=%h want 1/0/00", bus_if.empty, bus_if.full, bus_if.data_out);
    end
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b1);
    n_checks++;
    if (bus_if.empty !== 1'b1 || bus_if.data_out !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_pop got empty=%b dout=%h want 1/00", bus_if.empty, bus_if.data_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 99) < 45));
      n_checks++;
      if (bus_if.data_out !== exp_do || bus_if.full !== (q.size() == DP) || bus_if.empty !== (q.size() == 0)) begin
        n_fail++;
        $display("FAIL random[%0d] got dout=%h full=%b empty=%b want %h/%b/%b", i, bus_if.data_out, bus_if.full,
                 bus_if.empty, exp_do, q.size() == DP, q.size() == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_top.md
FIFO_TOP -- requirements
Module: fifo_top

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of data_in/data_out in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of storage entries (power of two).
REQ-003 SHALL have port clk, input, 1, single clock for all logic, rising-edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port push, input, 1, write request, sampled at the clk rising edge.
REQ-006 SHALL have port data_in, input, DATA_WIDTH, write data, captured when a push is accepted.
REQ-007 SHALL have port pop, input, 1, read request, sampled at the clk rising edge.
REQ-008 SHALL have port data_out, output, DATA_WIDTH, read data, registered.
REQ-009 SHALL have port full, output, 1, high when the stored count equals DEPTH.
REQ-010 SHALL have port empty, output, 1, high when the stored count equals 0.
REQ-011 SHALL group push, data_in, pop, data_out, full and empty in interface inFIFO; fifo_top SHALL connect them through modport fifoIn (push/data_in/pop inputs; data_out/full/empty outputs).

Function
REQ-012 SHALL store data in a DEPTH x DATA_WIDTH array addressed by write and read pointers of log2(DEPTH) bits.
REQ-013 SHALL track occupancy with a count of log2(DEPTH)+1 bits, covering 0..DEPTH.
REQ-014 SHALL accept a push when push=1 and full=0: writes data_in at wr_ptr, increments wr_ptr modulo DEPTH.
REQ-015 SHALL accept a pop when pop=1 and empty=0: loads data_out with mem[rd_ptr] at that edge (1-cycle latency), increments rd_ptr modulo DEPTH.
REQ-016 SHALL hold data_out unchanged on any edge with no accepted pop.
REQ-017 SHALL ignore a push while full=1 (overflow): no write, no pointer or count change, stored data intact.
REQ-018 SHALL ignore a pop while empty=1 (underflow): no pointer or count change, data_out holds.
REQ-019 SHALL, on simultaneous push and pop with 0 < count < DEPTH, perform both operations and leave count unchanged.
REQ-020 SHALL, on simultaneous push and pop when empty, perform only the push (count becomes 1).
REQ-021 SHALL, on simultaneous push and pop when full, perform both operations (the pop reads the oldest entry, the push fills the freed slot) and leave count at DEPTH.
REQ-022 SHALL drive full and empty combinationally from count (or as equivalent registered flags), valid in the same cycle count changes.
REQ-023 SHALL preserve strict first-in-first-out order across pointer wrap-around.

Reset
REQ-024 SHALL, while rst=0, asynchronously clear wr_ptr, rd_ptr and count to 0, data_out to 0, empty to 1 and full to 0.
REQ-025 SHALL ignore push and pop while rst=0; the first operation SHALL take effect at the first rising edge after rst deasserts.
REQ-026 SHALL, if reset asserts mid-operation, discard all stored contents immediately; memory contents need not be cleared.

Verification
REQ-027 Reset then idle -> empty=1, full=0, data_out=0.
REQ-028 Push 0x01..0x10 (16 words) -> full=1 after the 16th push; a 17th push of 0xFF is ignored; 16 pops return 0x01..0x10 in order; empty=1 after the last pop.
REQ-029 From empty, pop 3 times -> data_out stays 0, empty stays 1, and a subsequent push of 0xA5 followed by a pop returns 0xA5.
REQ-030 Push 10 words, pop 10, then push 0x20..0x2F (wrapping the pointers) -> 16 pops return 0x20..0x2F in order.
REQ-031 With 5 words stored, assert push and pop together for 8 cycles -> count stays 5 and the pops return the oldest words in order; when full, push+pop together keeps full=1 and returns the oldest word.
REQ-032 Push 4 words, assert rst=0 between clock edges -> empty=1 and full=0 immediately; after release, a pop yields no data and empty stays 1.
